// File: rtl/vga_pkg.sv
// Shared types for the VGA timing generator: pixel struct, FSM states, colour-bar palette
// and frame-geometry helpers.
package vga_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vga_state_t;

    localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
    localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
    localparam rgb_t BAR_CYAN    = 24'h00FFFF;
    localparam rgb_t BAR_GREEN   = 24'h00FF00;
    localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
    localparam rgb_t BAR_RED     = 24'hFF0000;
    localparam rgb_t BAR_BLUE    = 24'h0000FF;
    localparam rgb_t BAR_BLACK   = 24'h000000;

    function automatic int htotal(input int disp, input int fp, input int pulse, input int bp);
        return disp + fp + pulse + bp;
    endfunction

    function automatic int vtotal(input int disp, input int fp, input int pulse, input int bp);
        return disp + fp + pulse + bp;
    endfunction

    // Bar index 0 is the leftmost bar.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical position counter pair. Counts only while run is high and is
// cleared otherwise; frame_end flags the last pixel of the last line.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int HTOTAL = 928,
    parameter int VTOTAL = 525,
    parameter int HW     = $clog2(HTOTAL),
    parameter int VW     = $clog2(VTOTAL)
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst,
    input  logic          run,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          frame_end
);

    localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);

    logic line_end;

    assign line_end  = (hcnt == H_LAST);
    assign frame_end = line_end && (vcnt == V_LAST);

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!run) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (line_end) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD timing generator: counters -> pixel request stage -> pin stage.
// Optional internal colour bars are built when VGA_PATTERN_EN is defined.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   HDISP  = 800,
    parameter int   HFP    = 40,
    parameter int   HPULSE = 48,
    parameter int   HBP    = 40,
    parameter int   VDISP  = 480,
    parameter int   VFP    = 13,
    parameter int   VPULSE = 3,
    parameter int   VBP    = 29,
    parameter logic HS_POL = 1'b0,
    parameter logic VS_POL = 1'b0
) (
    input  logic                     pixel_clk,
    input  logic                     pixel_rst,
    input  logic                     enable,
    input  logic                     pattern_sel,
    output logic                     pix_req,
    output logic [$clog2(HDISP)-1:0] pix_x,
    output logic [$clog2(VDISP)-1:0] pix_y,
    input  logic [23:0]              rgb_in,
    output logic                     frame_start,
    output logic                     VGA_HS,
    output logic                     VGA_VS,
    output logic                     VGA_BLANK,
    output logic [23:0]              VGA_RGB
);

    localparam int HTOTAL = htotal(HDISP, HFP, HPULSE, HBP);
    localparam int VTOTAL = vtotal(VDISP, VFP, VPULSE, VBP);
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int XW     = $clog2(HDISP);
    localparam int YW     = $clog2(VDISP);

    localparam logic [HW-1:0] H_ACT_END  = HW'(HDISP);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(HDISP + HFP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(HDISP + HFP + HPULSE);
    localparam logic [VW-1:0] V_ACT_END  = VW'(VDISP);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(VDISP + VFP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(VDISP + VFP + VPULSE);

    vga_state_t    state, state_nxt;
    logic          run;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          frame_end;

    logic          req0, hs0, vs0, fs0;
    logic [2:1]    vld_pipe;
    logic          hs1, vs1;
    rgb_t          rgb_src;

    assign run = (state == ST_RUN);

    vga_sync_counter #(
        .HTOTAL (HTOTAL),
        .VTOTAL (VTOTAL),
        .HW     (HW),
        .VW     (VW)
    ) u_cnt (
        .pixel_clk (pixel_clk),
        .pixel_rst (pixel_rst),
        .run       (run),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .frame_end (frame_end)
    );

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // Dropping enable mid-frame only takes effect at the frame wrap.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable)                 state_nxt = ST_RUN;
            ST_RUN:  if (frame_end && !enable)   state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req0 = 1'b0;
        hs0  = 1'b0;
        vs0  = 1'b0;
        fs0  = 1'b0;
        if (run) begin
            req0 = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
            hs0  = (hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END);
            vs0  = (vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END);
            fs0  = (hcnt == '0) && (vcnt == '0);
        end
    end

    // Stage 1: request to the frame-buffer reader plus delayed sync flags.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            vld_pipe    <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            hs1         <= 1'b0;
            vs1         <= 1'b0;
        end else begin
            vld_pipe    <= {vld_pipe[1], req0};
            pix_x       <= req0 ? hcnt[XW-1:0] : '0;
            pix_y       <= req0 ? vcnt[YW-1:0] : '0;
            frame_start <= fs0;
            hs1         <= hs0;
            vs1         <= vs0;
        end
    end

    assign pix_req   = vld_pipe[1];
    assign VGA_BLANK = vld_pipe[2];

`ifdef VGA_PATTERN_EN
    localparam int BAR_W = (HDISP / 8 > 0) ? HDISP / 8 : 1;

    logic [2:0] bar_idx;

    // Smallest bar whose right edge lies beyond the column; the last bar takes the remainder.
    always_comb begin
        bar_idx = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (int'(pix_x) < (i + 1) * BAR_W) bar_idx = 3'(i);
        end
    end

    always_comb begin
        rgb_src = rgb_in;
        if (pattern_sel) rgb_src = bar_colour(bar_idx);
    end
`else
    logic unused_pattern_sel;

    assign unused_pattern_sel = pattern_sel;
    assign rgb_src            = rgb_in;
`endif

    // Stage 2: pin registers, all aligned two cycles behind the counters.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            VGA_HS  <= ~HS_POL;
            VGA_VS  <= ~VS_POL;
            VGA_RGB <= '0;
        end else begin
            VGA_HS  <= hs1 ? HS_POL : ~HS_POL;
            VGA_VS  <= vs1 ? VS_POL : ~VS_POL;
            VGA_RGB <= vld_pipe[1] ? 24'(rgb_src) : 24'h0;
        end
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor of the fixed 800x480 VGA line/pixel counter: generates horizontal/vertical sync, display-enable and pixel coordinates for any porch/pulse geometry, with configurable sync polarity and a runtime enable. Issues a pixel request one cycle ahead so an upstream frame-buffer reader can return RGB in time, and drives pin-aligned outputs. Sits between the frame-buffer read path and the LCD/VGA pins in the pixel_clk domain.

## Interface
- HDISP, 800, active pixels per line
- HFP, 40, horizontal front porch (pixels)
- HPULSE, 48, horizontal sync width (pixels)
- HBP, 40, horizontal back porch (pixels)
- VDISP, 480, active lines per frame
- VFP, 13, vertical front porch (lines)
- VPULSE, 3, vertical sync width (lines)
- VBP, 29, vertical back porch (lines)
- HS_POL, 0, active level of VGA_HS (0 = active-low)
- VS_POL, 0, active level of VGA_VS
- pixel_clk  in  1  pixel clock, only clock
- pixel_rst  in  1  asynchronous, active-high reset
- enable  in  1  run timing; sampled only at frame boundary
- pattern_sel  in  1  select internal colour bars (only with VGA_PATTERN_EN)
- pix_req  out  1  request RGB for (pix_x, pix_y); one-cycle pulse per active pixel
- pix_x  out  $clog2(HDISP)  requested pixel column
- pix_y  out  $clog2(VDISP)  requested pixel row
- rgb_in  in  24  RGB returned exactly one cycle after pix_req
- frame_start  out  1  one-cycle pulse with the request of pixel (0,0)
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- VGA_BLANK  out  1  high during active video (display enable)
- VGA_RGB  out  24  pixel colour, 0 when VGA_BLANK low

## Operation
- HTOTAL = HDISP+HFP+HPULSE+HBP, VTOTAL = VDISP+VFP+VPULSE+VBP; counters widths $clog2(HTOTAL), $clog2(VTOTAL).
- hcnt counts 0..HTOTAL-1 then wraps to 0, incrementing vcnt; vcnt counts 0..VTOTAL-1 then wraps to 0. No off-by-one: a line is exactly HTOTAL cycles.
- Horizontal order: active [0,HDISP), front porch, sync [HDISP+HFP, HDISP+HFP+HPULSE), back porch. Vertical identical with V parameters, in lines.
- HS active when hcnt in sync window; VS active when vcnt in sync window (full lines, changes at hcnt=0). Output level = HS_POL/VS_POL when active, inverse otherwise.
- States: IDLE (counters held at 0, no requests, syncs inactive, BLANK low) and RUN. IDLE->RUN when enable=1 in IDLE. RUN->IDLE only at the wrap from (HTOTAL-1, VTOTAL-1) with enable=0; deasserting enable mid-frame completes the frame.
- pix_req = RUN and hcnt<HDISP and vcnt<VDISP; pix_x=hcnt, pix_y=vcnt when pix_req, else hold 0.

## Timing
- Stage 0: counters (cycle t). Stage 1 (t+1): registered pix_req, pix_x, pix_y, frame_start, plus delayed sync/blank. Stage 2 (t+2): VGA_HS, VGA_VS, VGA_BLANK, VGA_RGB registered; VGA_RGB = rgb_in captured when stage-1 pix_req was high.
- Pin latency 2 cycles from counters; rgb_in sampled the cycle after pix_req, all pins mutually aligned.
- Reset (any time, including mid-frame): state IDLE, counters 0, pix_req/frame_start/VGA_BLANK 0, pix_x/pix_y 0, VGA_RGB 0, VGA_HS=~HS_POL, VGA_VS=~VS_POL.
- First pix_req is 1 cycle after entering RUN's first counted cycle; frame_start coincides with it each frame.

## Configuration
- VGA_PATTERN_EN defined: pattern_sel=1 replaces rgb_in with 8 vertical bars each HDISP/8 wide (last bar absorbs remainder): white, yellow, cyan, green, magenta, red, blue, black; same latency as rgb_in path.
- Undefined: pattern_sel port present but ignored; VGA_RGB always from rgb_in.

## Structure
- vga_pkg: rgb_t (24-bit packed r,g,b), colour-bar constants, htotal/vtotal functions.
- Sub-module vga_sync_counter: hcnt/vcnt pair with wrap and terminal-count flag; instantiated once.

## Test plan
- Default params, enable=1: VGA_HS period 928 cycles, low 48 cycles starting 840 cycles after first BLANK rise; VS period 928*525 = 487200 cycles, low 3 lines.
- rgb_in = {pix_y[7:0], pix_x[7:0], 8'hA5}: pixel (5,7) appears on VGA_RGB 2 cycles after its counter cycle with BLANK high; RGB=0 in blanking.
- HS_POL=1, VS_POL=1, HDISP=16, HFP=2, HPULSE=3, HBP=1, VDISP=4, VFP=1, VPULSE=1, VBP=1: HS high exactly 3 of every 22 cycles; 64 pix_req per frame.
- enable dropped at line 100: frame completes to vcnt=524 wrap, then no pix_req, syncs inactive; re-assert -> frame_start one cycle after restart.
- pixel_rst asserted mid-line: all outputs reach reset values asynchronously; after release first frame_start precedes any HS pulse.
- VGA_PATTERN_EN, pattern_sel=1: column 0 = 24'hFFFFFF, column 100 = 24'hFFFF00, column 799 = 24'h000000.
